// File: rtl/mem_io_responder.sv
// mem_io_responder
//
// Memory/IO-side responder for the control sequencer's load/store strobes.
// A RAM operation completes after a programmable number of wait states,
// an IN operation completes when the device offers data, and an OUT
// operation completes when the device accepts data. Every accepted operation
// ends with a single-cycle done pulse, which releases the control stall.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   do_memload         load strobe (1 cycle)
//   do_memstore        store strobe (1 cycle)
//   is_io              1 = IN/OUT operation, 0 = RAM operation
//   addr, wdata        address/port and store data, sampled with the strobe
//   rdata              last load result, held until the next load completes
//   done               1-cycle completion pulse
//   busy               high from the cycle after acceptance until done
//   err                sticky protocol-error flag
//   io_port            port number of the current IO operation
//   in_valid/in_ready/in_data      input-device handshake
//   out_valid/out_ready/out_data   output-device handshake

module mem_io_responder #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_WAIT  = 2,
    parameter int PORT_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 do_memload,
    input  logic                 do_memstore,
    input  logic                 is_io,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 done,
    output logic                 busy,
    output logic                 err,
    output logic [PORT_BITS-1:0] io_port,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MEMWAIT,
        IOIN,
        IOOUT
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 store_q, store_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [PORT_BITS-1:0] io_port_q, io_port_d;
    logic [WORD_SIZE-1:0] out_data_q, out_data_d;
    logic                 mem_we;

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic any_strobe;
    logic both_strobes;
    logic one_strobe;

    assign any_strobe   = do_memload | do_memstore;
    assign both_strobes = do_memload & do_memstore;
    assign one_strobe   = do_memload ^ do_memstore;

    // Upper address bits beyond the RAM index are intentionally dropped:
    // RAM addresses wrap modulo MEM_DEPTH.
    generate
        if (ADDR_SIZE > IDX_W) begin : g_addr_wrap
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_SIZE-1:IDX_W];
        end
    endgenerate

    // Next-state and datapath logic. Protocol errors only raise err; the
    // offending strobe is dropped and any in-flight operation carries on.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        store_d    = store_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        io_port_d  = io_port_q;
        out_data_d = out_data_q;
        mem_we     = 1'b0;
        err_d      = err_q | both_strobes | (any_strobe & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (one_strobe) begin
                    idx_d   = addr[IDX_W-1:0];
                    wdata_d = wdata;
                    store_d = do_memstore;
                    if (!is_io) begin
                        state_d = MEMWAIT;
                        cnt_d   = 4'(MEM_WAIT);
                    end else begin
                        io_port_d = addr[PORT_BITS-1:0];
                        if (do_memstore) begin
                            state_d    = IOOUT;
                            out_data_d = wdata;
                        end else begin
                            state_d = IOIN;
                        end
                    end
                end
            end
            MEMWAIT: begin
                if (cnt_q == 4'd0) begin
                    // Gating the write with rst_n keeps a reset that lands
                    // on the access edge from corrupting RAM.
                    if (store_q) begin
                        mem_we = rst_n;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            IOIN: begin
                if (in_valid) begin
                    rdata_d = in_data;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            IOOUT: begin
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            store_q    <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            io_port_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            store_q    <= store_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            io_port_q  <= io_port_d;
            out_data_q <= out_data_d;
        end
    end

    // RAM array has no reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign io_port   = io_port_q;
    assign in_ready  = (state_q == IOIN);
    assign out_valid = (state_q == IOOUT);
    assign out_data  = out_data_q;

endmodule
